// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read/one-write register file.
//   rf_state_t : clear-sequencer states (CLEAR while zeroing storage, READY after)
//   RF_XLEN    : default data width
//   RF_NREGS   : default register count
//   rf_idx_ok  : true when an index names a real, writable/readable register
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    // An index is usable when it lies inside the array and is not the
    // hardwired-zero register (when that option is enabled).
    function automatic logic rf_idx_ok(input int unsigned idx,
                                       input int unsigned nregs,
                                       input logic        zero_reg);
        return (idx < nregs) && !(zero_reg && (idx == 0));
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer for regfile_2r1w.
// Walks cnt from 0 to NREGS-1, requesting one zero write per cycle, then
// settles in READY until the next reset.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, restarts the sequence
//   ready    : high once every register has been cleared
//   clr_we   : clear write request (active for the whole CLEAR state)
//   clr_addr : register being cleared this cycle
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            // The write to LAST_IDX happens on this same edge, so the
            // storage is fully zeroed when READY is entered.
            if (cnt_q == LAST_IDX) begin
                state_d = READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // Pure decodes of flops: no combinational path from any input.
    assign ready    = (state_q == READY);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with sequenced post-reset clear.
// Parameters:
//   XLEN     : data width
//   NREGS    : number of registers (2..256)
//   ZERO_REG : nonzero -> register 0 reads as 0, writes to it are dropped
//   BYPASS   : nonzero -> same-cycle write data is forwarded to reads
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   ready      : clear sequence finished, accesses accepted
//   r          : read enable for both ports
//   rs1, rs2   : read indices
//   rs1v, rs2v : registered read data (1-cycle latency, held when r=0)
//   we, rd, din: write enable, write index, write data
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic            r,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1v,
    output logic [XLEN-1:0] rs2v,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] din
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            user_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem [NREGS];
    logic [AW-1:0]   rd_idx [2];

    regfile_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write needs READY, no reset this cycle, and a legal target.
    assign user_we = ready && we && !rst &&
                     rf_idx_ok(32'(rd), NREGS, ZERO_REG != 0);

    // The clear sequencer and the user port never overlap (CLEAR vs READY),
    // so a simple priority mux shares the single write port.
    assign mem_we    = clr_we || user_we;
    assign mem_waddr = clr_we ? clr_addr : rd;
    assign mem_wdata = clr_we ? '0 : din;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_idx[0] = rs1;
    assign rd_idx[1] = rs2;

    // Identical read ports; each reads the pre-write array contents so the
    // non-bypass case returns the old value on a same-cycle collision.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic            idx_ok;
        logic            hit;
        logic [XLEN-1:0] rsv_q, rsv_d;

        always_comb begin
            idx_ok = rf_idx_ok(32'(rd_idx[gi]), NREGS, ZERO_REG != 0);
            hit    = (BYPASS != 0) && user_we && (rd == rd_idx[gi]);
            rsv_d  = rsv_q;
            if (rst) begin
                rsv_d = '0;
            end else if (ready && r) begin
                if (!idx_ok) begin
                    rsv_d = '0;
                end else if (hit) begin
                    rsv_d = din;
                end else begin
                    rsv_d = mem[rd_idx[gi]];
                end
            end
        end

        always_ff @(posedge clk) begin
            rsv_q <= rsv_d;
        end
    end

    assign rs1v = g_port[0].rsv_q;
    assign rs2v = g_port[1].rsv_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w. Two instances share one stimulus:
//   dut_a : NREGS=32, ZERO_REG=1, BYPASS=1
//   dut_b : NREGS=24, ZERO_REG=0, BYPASS=0
// A behavioural model (plain arrays plus a clear-cycle countdown) predicts
// ready/rs1v/rs2v after every edge and queues them; a monitor pops and
// compares on the falling edge.
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst, r, we;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] din;
    logic        ready_a, ready_b;
    logic [31:0] a1, a2, b1, b2;

    always #5 clk = ~clk;

    regfile_2r1w #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a), .r(r), .rs1(rs1), .rs2(rs2),
        .rs1v(a1), .rs2v(a2), .we(we), .rd(rd), .din(din)
    );

    regfile_2r1w #(.XLEN(32), .NREGS(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .r(r), .rs1(rs1), .rs2(rs2),
        .rs1v(b1), .rs2v(b2), .we(we), .rd(rd), .din(din)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] o1;
        logic [31:0] o2;
        bit          rd_op;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state, one slot per instance.
    int          mn  [2] = '{32, 24};
    bit          mz  [2] = '{1'b1, 1'b0};
    bit          mbp [2] = '{1'b1, 1'b0};
    logic [31:0] mmem[2][32];
    int          mclr[2] = '{0, 0};
    logic [31:0] mo1 [2];
    logic [31:0] mo2 [2];

    function automatic logic [31:0] rval(input int k, input int idx, input bit wv);
        if (idx >= mn[k] || (mz[k] && idx == 0)) return 32'h0;
        if (mbp[k] && wv && int'(rd) == idx) return din;
        return mmem[k][idx];
    endfunction

    // Predict the outputs visible after the coming edge for instance k,
    // using the inputs currently driven.
    task automatic model_step(input int k);
        exp_t e;
        bit   wv;
        e.rd_op = 1'b0;
        if (rst) begin
            mclr[k] = mn[k];
            mo1[k]  = '0;
            mo2[k]  = '0;
            for (int i = 0; i < 32; i++) mmem[k][i] = '0;
        end else if (mclr[k] > 0) begin
            mclr[k]--;
        end else begin
            wv = we && (int'(rd) < mn[k]) && !(mz[k] && rd == 5'd0);
            if (r) begin
                mo1[k]  = rval(k, int'(rs1), wv);
                mo2[k]  = rval(k, int'(rs2), wv);
                e.rd_op = 1'b1;
            end
            if (wv) mmem[k][rd] = din;
        end
        e.rdy = (mclr[k] == 0);
        e.o1  = mo1[k];
        e.o2  = mo2[k];
        if (k == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic step(input bit i_rst, input bit i_r, input int i_rs1, input int i_rs2,
                        input bit i_we, input int i_rd, input logic [31:0] i_din);
        rst = i_rst;
        r   = i_r;
        rs1 = 5'(i_rs1);
        rs2 = 5'(i_rs2);
        we  = i_we;
        rd  = 5'(i_rd);
        din = i_din;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
    endtask

    task automatic read_all();
        for (int i = 0; i < 32; i += 2) step(1'b0, 1'b1, i, i + 1, 1'b0, 0, 32'h0);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: one popped prediction per DUT per falling edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        cyc++;
        if (qa.size() > 0 && qb.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            cmp("a_ready", 32'(ready_a), 32'(ea.rdy));
            cmp("a_rs1v", a1, ea.o1);
            cmp("a_rs2v", a2, ea.o2);
            cmp("b_ready", 32'(ready_b), 32'(eb.rdy));
            cmp("b_rs1v", b1, eb.o1);
            cmp("b_rs2v", b2, eb.o2);
            if (ea.rd_op)
                $display("cycle %0d read: A rs1v=%h rs2v=%h | B rs1v=%h rs2v=%h",
                         cyc, a1, a2, b1, b2);
        end
    end

    initial begin
        // Reset, then hold r=1 (with stray writes) through the clear phase.
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 33; i++)
            step(1'b0, 1'b1, i % 32, 31 - (i % 32), 1'b1, i % 32, 32'hA5A5_0000 + 32'(i));
        read_all();

        // Write then read.
        step(1'b0, 1'b0, 0, 0, 1'b1, 5, 32'hDEADBEEF);
        step(1'b0, 1'b1, 5, 0, 1'b0, 0, 32'h0);

        // Same-cycle collision on register 7.
        step(1'b0, 1'b0, 0, 0, 1'b1, 7, 32'h0000_0055);
        step(1'b0, 1'b1, 7, 7, 1'b1, 7, 32'h0000_1234);
        step(1'b0, 1'b1, 7, 5, 1'b0, 0, 32'h0);

        // Register 0: written and read in the same cycle, then read again.
        step(1'b0, 1'b1, 0, 0, 1'b1, 0, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 0, 0, 1'b0, 0, 32'h0);

        // Index 30: out of range for the 24-entry instance.
        step(1'b0, 1'b1, 30, 23, 1'b1, 30, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 30, 30, 1'b0, 0, 32'h0);

        for (int i = 0; i < 300; i++) rand_step();
        read_all();

        // Reset at clear cycle 10, with random traffic during both clears.
        step(1'b1, 1'b1, 3, 4, 1'b1, 3, 32'h1111_1111);
        for (int i = 0; i < 10; i++) rand_step();
        step(1'b1, 1'b0, 0, 0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 33; i++) rand_step();
        read_all();

        for (int i = 0; i < 200; i++) rand_step();
        read_all();

        // Let the monitor drain the last predictions.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file, successor to the single-port-mode register file. Integer pipeline register stage: decode reads `rs1`/`rs2`, writeback writes `rd`. Differences from the previous generation:
- Independent read and write enables, so both can occur in the same cycle.
- Configurable width and depth.
- Optional hardwired-zero register 0.
- Optional write-to-read bypass.
- Sequenced post-reset clear with a `ready` flag, instead of a single-cycle bulk clear.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers (2..256); `AW = max(1, $clog2(NREGS))`.
- `ZERO_REG`, 1, when 1, register 0 always reads 0 and writes to it are dropped.
- `BYPASS`, 1, when 1, a same-cycle write to a register being read forwards `din` to the read output.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ready`  out  1  high when the clear sequence is done and the file accepts accesses.
- `r`  in  1  read enable; captures both read ports.
- `rs1`  in  AW  read index, port 1.
- `rs2`  in  AW  read index, port 2.
- `rs1v`  out  XLEN  registered read data, port 1.
- `rs2v`  out  XLEN  registered read data, port 2.
- `we`  in  1  write enable.
- `rd`  in  AW  write index.
- `din`  in  XLEN  write data.

## Operation
- FSM states: CLEAR, READY.
- `rst` high:
  - next state CLEAR, clear counter `cnt` = 0.
  - `ready` = 0, `rs1v` = `rs2v` = 0.
  - `rst` has priority over every other input.
- CLEAR:
  - each cycle writes 0 to `mem[cnt]` and increments `cnt`.
  - when `cnt == NREGS-1`, that write completes and the next state is READY.
  - `r` and `we` are ignored; `rs1v`/`rs2v` hold 0.
- READY:
  - `we=1` and `rd` valid: `mem[rd] <= din`.
  - `rd` is invalid if it is >= `NREGS`, or if `ZERO_REG=1` and `rd==0`; invalid writes are dropped silently.
  - `r=1`: each port independently loads `rsNv` with:
    - 0 if the index is >= `NREGS` or (`ZERO_REG=1` and the index is 0);
    - else `din` if `BYPASS=1`, `we=1` and `rd` equals the index (valid write);
    - else `mem[index]`, the pre-write value.
  - `r=0`: `rs1v`/`rs2v` hold their previous values.
  - `rs1 == rs2` is legal; both ports return the same value.
- With `BYPASS=0`, a same-cycle read and write to the same register returns the old value; the new value is visible from the next read.
- There is no way back to CLEAR except via `rst`.

## Timing
- Read latency: 1 cycle. Indices are sampled on edge N and the data is valid after edge N, until the next enabled read.
- Write latency: 1 cycle. Data written on edge N is visible to a read sampled on edge N+1; with `BYPASS=1` it is also visible to a read sampled on edge N.
- Clear duration: `NREGS` cycles.
  - If `rst` is sampled high on edge 0 and low afterwards, CLEAR writes occur on edges 1..NREGS.
  - `ready` rises after edge NREGS.
  - The first accepted access is on edge NREGS+1.
- `rst` asserted mid-clear restarts from `cnt` = 0. `rst` asserted in READY drops `ready` on the next edge.
- `ready` is a registered output with no combinational path from the inputs.

## Structure
- Shared package `regfile_pkg`:
  - `rf_state_t` enum {CLEAR, READY}.
  - default constants `RF_XLEN` = 32 and `RF_NREGS` = 32.
- Sub-module `regfile_clear_ctrl`:
  - contains the FSM and `cnt`;
  - outputs `ready`, `clr_we`, `clr_addr`.
- The top level muxes the clear write against the user write and holds the storage array and the read/bypass logic.

## Test plan
- Reset then idle: assert `rst` for 1 cycle, then hold `r=1`. Required: `ready` = 0 for exactly 32 cycles then 1; every register reads 0 after `ready`.
- Write/read: in READY, write `rd=5`, `din=0xDEADBEEF`; next cycle read `rs1=5`, `rs2=0`. Required: `rs1v=0xDEADBEEF`, `rs2v=0` one cycle later.
- Bypass: same cycle `we=1`, `rd=7`, `din=0x1234`, `r=1`, `rs1=7`, where `mem[7]` was 0x55.
  - `BYPASS=1`: `rs1v=0x1234`.
  - `BYPASS=0`: `rs1v=0x55`, and a read on the next cycle returns 0x1234.
- Zero register: with `ZERO_REG=1`, write `rd=0`, `din=0xFFFFFFFF`, then read `rs1=rs2=0`. Required: both read 0, including on the same-cycle bypass path.
- Reset mid-clear: assert `rst` at clear cycle 10. Required: `ready` rises exactly 32 cycles after the second reset; `r`/`we` asserted during CLEAR leave outputs at 0 and memory unchanged.
- Non-power-of-2 depth, `NREGS=24`: a write to `rd=30` is dropped, a read of index 30 returns 0, and `ready` rises after 24 clear cycles.
